// File: rtl/mem_dcache_assoc.sv
// Set-associative, write-back, write-allocate data cache with round-robin replacement,
// line-granular fill and write-back over a word-wide bus, and a whole-cache flush.
module mem_dcache_assoc #(
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2,
    parameter int LINE_WORDS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dreq_valid,
    output logic        dreq_ready,
    input  logic [31:0] dreq_addr,
    input  logic        dreq_wen,
    input  logic [31:0] dreq_wdata,
    input  logic [3:0]  dreq_wmask,
    output logic        dresp_valid,
    output logic [31:0] dresp_rdata,
    input  logic        flush_valid,
    output logic        flush_done,
    output logic        busreq_valid,
    input  logic        busreq_ready,
    output logic [31:0] busreq_addr,
    output logic        busreq_wen,
    output logic [31:0] busreq_wdata,
    input  logic        busresp_valid,
    input  logic [31:0] busresp_rdata
);
    localparam int OW    = $clog2(LINE_WORDS);
    localparam int OWS   = (OW > 0) ? OW : 1;
    localparam int TAG_W = 30 - OW - INDEX_WIDTH;
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OWS-1:0]         LAST_WORD = OWS'(LINE_WORDS - 1);
    localparam logic [WW-1:0]          LAST_WAY  = WW'(WAYS - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_SET  = '1;

    typedef enum logic [2:0] {IDLE, WB, FILL, RESP, FLUSH} state_t;
    state_t state, state_next;

    logic [31:0]      data_mem   [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_mem    [WAYS][SETS];
    logic [WAYS-1:0]  valid_bits [SETS];
    logic [WAYS-1:0]  dirty_bits [SETS];
    logic [WW-1:0]    rr_ptr     [SETS];

    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [OWS-1:0]         req_word;
    logic                   req_wen;
    logic [31:0]            req_wdata;
    logic [3:0]             req_wmask;
    logic [WW-1:0]          victim;
    logic [OWS-1:0]         beat;
    logic                   wait_resp;
    logic [INDEX_WIDTH-1:0] flush_set;
    logic [WW-1:0]          flush_way;
    logic                   hit_resp;
    logic [31:0]            hit_rdata;
    logic                   flush_done_q;

    logic [TAG_W-1:0]       in_tag;
    logic [INDEX_WIDTH-1:0] in_index;
    logic [OWS-1:0]         in_word;
    logic                   hit;
    logic [WW-1:0]          hit_way;
    logic                   has_invalid;
    logic [WW-1:0]          victim_sel;
    logic                   victim_dirty;
    logic                   flush_line_dirty;
    logic                   flush_line_done;
    logic                   beat_last;
    logic                   addr_lsb_unused;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_WIDTH-1:0] index,
                                              input logic [OWS-1:0] word);
        logic [31:0] a;
        a = '0;
        a[31 -: TAG_W] = tag;
        a[2 + OW +: INDEX_WIDTH] = index;
        if (OW > 0) a[2 +: OWS] = word;
        return a;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0] mask);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = mask[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        return m;
    endfunction

    assign in_tag          = dreq_addr[31 -: TAG_W];
    assign in_index        = dreq_addr[2 + OW +: INDEX_WIDTH];
    assign in_word         = (OW > 0) ? dreq_addr[2 +: OWS] : '0;
    assign addr_lsb_unused = ^dreq_addr[1:0];
    assign beat_last       = (beat == LAST_WORD);

    // Walking down from the top way leaves the lowest-numbered invalid way as victim.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        victim_sel  = rr_ptr[in_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_bits[in_index][w] && tag_mem[w][in_index] == in_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_bits[in_index][w]) begin
                has_invalid = 1'b1;
                victim_sel  = WW'(w);
            end
        end
        victim_dirty     = valid_bits[in_index][victim_sel] && dirty_bits[in_index][victim_sel];
        flush_line_dirty = valid_bits[flush_set][flush_way] && dirty_bits[flush_set][flush_way];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        busreq_valid    = 1'b0;
        busreq_addr     = '0;
        busreq_wen      = 1'b0;
        busreq_wdata    = '0;
        flush_line_done = 1'b0;
        case (state)
            IDLE: begin
                if (flush_valid)                state_next = FLUSH;
                else if (dreq_valid && !hit)    state_next = victim_dirty ? WB : FILL;
            end
            WB: begin
                busreq_valid = 1'b1;
                busreq_wen   = 1'b1;
                busreq_addr  = line_addr(tag_mem[victim][req_index], req_index, beat);
                busreq_wdata = data_mem[victim][req_index][beat];
                if (busreq_ready && beat_last) state_next = FILL;
            end
            FILL: begin
                if (!wait_resp) begin
                    busreq_valid = 1'b1;
                    busreq_addr  = line_addr(req_tag, req_index, beat);
                end else if (busresp_valid && beat_last) begin
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            FLUSH: begin
                if (flush_line_dirty) begin
                    busreq_valid    = 1'b1;
                    busreq_wen      = 1'b1;
                    busreq_addr     = line_addr(tag_mem[flush_way][flush_set], flush_set, beat);
                    busreq_wdata    = data_mem[flush_way][flush_set][beat];
                    flush_line_done = busreq_ready && beat_last;
                end else begin
                    flush_line_done = 1'b1;
                end
                if (flush_line_done && flush_way == LAST_WAY && flush_set == LAST_SET)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dreq_ready  = (state == IDLE) && !flush_valid;
    assign dresp_valid = hit_resp || (state == RESP);
    assign dresp_rdata = (state == RESP) ? data_mem[victim][req_index][req_word] : hit_rdata;
    assign flush_done  = flush_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_bits[s] <= '0;
                dirty_bits[s] <= '0;
                rr_ptr[s]     <= '0;
            end
            req_tag      <= '0;
            req_index    <= '0;
            req_word     <= '0;
            req_wen      <= 1'b0;
            req_wdata    <= '0;
            req_wmask    <= '0;
            victim       <= '0;
            beat         <= '0;
            wait_resp    <= 1'b0;
            flush_set    <= '0;
            flush_way    <= '0;
            hit_resp     <= 1'b0;
            hit_rdata    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            hit_resp     <= 1'b0;
            flush_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_valid) begin
                        flush_set <= '0;
                        flush_way <= '0;
                        beat      <= '0;
                    end else if (dreq_valid && hit) begin
                        hit_resp  <= 1'b1;
                        hit_rdata <= data_mem[hit_way][in_index][in_word];
                        if (dreq_wen) dirty_bits[in_index][hit_way] <= 1'b1;
                    end else if (dreq_valid) begin
                        req_tag   <= in_tag;
                        req_index <= in_index;
                        req_word  <= in_word;
                        req_wen   <= dreq_wen;
                        req_wdata <= dreq_wdata;
                        req_wmask <= dreq_wmask;
                        victim    <= victim_sel;
                        beat      <= '0;
                        wait_resp <= 1'b0;
                        // The line is dropped now so a reset mid-refill never exposes mixed data.
                        valid_bits[in_index][victim_sel] <= 1'b0;
                        if (!has_invalid)
                            rr_ptr[in_index] <= (rr_ptr[in_index] == LAST_WAY) ? '0 : rr_ptr[in_index] + 1'b1;
                    end
                end
                WB: begin
                    if (busreq_ready) beat <= beat_last ? '0 : beat + 1'b1;
                end
                FILL: begin
                    if (!wait_resp) begin
                        if (busreq_ready) wait_resp <= 1'b1;
                    end else if (busresp_valid) begin
                        wait_resp <= 1'b0;
                        beat      <= beat_last ? '0 : beat + 1'b1;
                        if (beat_last) begin
                            valid_bits[req_index][victim] <= 1'b1;
                            dirty_bits[req_index][victim] <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    if (req_wen) dirty_bits[req_index][victim] <= 1'b1;
                end
                FLUSH: begin
                    if (flush_line_dirty && busreq_ready) beat <= beat_last ? '0 : beat + 1'b1;
                    if (flush_line_done) begin
                        valid_bits[flush_set][flush_way] <= 1'b0;
                        dirty_bits[flush_set][flush_way] <= 1'b0;
                        if (flush_way == LAST_WAY) begin
                            flush_way <= '0;
                            flush_set <= flush_set + 1'b1;
                            if (flush_set == LAST_SET) flush_done_q <= 1'b1;
                        end else begin
                            flush_way <= flush_way + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage has no reset; validity alone decides whether contents matter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (!flush_valid && dreq_valid && hit && dreq_wen)
                        data_mem[hit_way][in_index][in_word] <=
                            merge_bytes(data_mem[hit_way][in_index][in_word], dreq_wdata, dreq_wmask);
                end
                FILL: begin
                    if (wait_resp && busresp_valid) begin
                        data_mem[victim][req_index][beat] <= busresp_rdata;
                        if (beat_last) tag_mem[victim][req_index] <= req_tag;
                    end
                end
                RESP: begin
                    if (req_wen)
                        data_mem[victim][req_index][req_word] <=
                            merge_bytes(data_mem[victim][req_index][req_word], req_wdata, req_wmask);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dcache_assoc.sv
// Self-checking bench for mem_dcache_assoc: vector table plus hand-written sequences
// for bus stalls, flush and reset mid-fill, with a response scoreboard and bus model.
module tb_mem_dcache_assoc;
    logic        clk;
    logic        rst_n;
    logic        dreq_valid;
    logic        dreq_ready;
    logic [31:0] dreq_addr;
    logic        dreq_wen;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_wmask;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        flush_valid;
    logic        flush_done;
    logic        busreq_valid;
    logic        busreq_ready;
    logic [31:0] busreq_addr;
    logic        busreq_wen;
    logic [31:0] busreq_wdata;
    logic        busresp_valid;
    logic [31:0] busresp_rdata;

    mem_dcache_assoc #(.INDEX_WIDTH(6), .WAYS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .flush_valid(flush_valid), .flush_done(flush_done),
        .busreq_valid(busreq_valid), .busreq_ready(busreq_ready), .busreq_addr(busreq_addr),
        .busreq_wen(busreq_wen), .busreq_wdata(busreq_wdata),
        .busresp_valid(busresp_valid), .busresp_rdata(busresp_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] rd_base;
        logic [31:0] wr_base;
        logic [31:0] wr_data0;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        check_data;
        int          due;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } bus_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    sb_t         sb[$];
    bus_t        bus_log[$];
    logic [31:0] stall_addrs[$];
    int          stall_cycs[$];
    int          stall_left = 0;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_data = '0;
    logic [31:0] mem_wr [logic [31:0]];
    vec_t        vecs[11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return a ^ 32'h5A5A0000;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Bus slave: ready unless stalling, one-cycle read response after each accepted read.
    initial begin
        bus_t t;
        busreq_ready  = 1'b0;
        busresp_valid = 1'b0;
        busresp_rdata = '0;
        forever begin
            @(negedge clk);
            busresp_valid = 1'b0;
            if (rd_pending) begin
                busresp_valid = 1'b1;
                busresp_rdata = rd_data;
                rd_pending    = 1'b0;
            end
            busreq_ready = (stall_left == 0);
            if (busreq_valid && rst_n) begin
                if (!busreq_ready) begin
                    stall_addrs.push_back(busreq_addr);
                    stall_cycs.push_back(cyc);
                    stall_left--;
                end else begin
                    t.addr  = busreq_addr;
                    t.wen   = busreq_wen;
                    t.wdata = busreq_wdata;
                    bus_log.push_back(t);
                    if (busreq_wen) mem_wr[busreq_addr] = busreq_wdata;
                    else begin
                        rd_pending = 1'b1;
                        rd_data    = mem_read(busreq_addr);
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every dresp_valid pulse.
    initial begin
        sb_t it;
        forever begin
            @(negedge clk);
            if (rst_n && dresp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got dresp_valid=1, required no response");
                end else begin
                    it = sb.pop_front();
                    if (it.check_data) chk32("dresp_rdata", dresp_rdata, it.rdata);
                    if (it.due != 0) chk_int("hit_latency_cycle", cyc, it.due);
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        sb_t it;
        int  n;
        bus_log.delete();
        @(negedge clk);
        dreq_valid = 1'b1;
        dreq_addr  = v.addr;
        dreq_wen   = v.wen;
        dreq_wdata = v.wdata;
        dreq_wmask = v.wmask;
        n = 0;
        while (!dreq_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_int("dreq_ready_wait", int'(dreq_ready), 1);
        it.rdata      = v.exp_rdata;
        it.check_data = !v.wen;
        it.due        = v.exp_hit ? cyc + 1 : 0;
        sb.push_back(it);
        @(negedge clk);
        dreq_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk_int("resp_pending_after_wait", sb.size(), 0);
        sb.delete();
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        int nrd;
        int nwr;
        nrd = 0;
        nwr = 0;
        foreach (bus_log[k]) begin
            if (bus_log[k].wen) begin
                if (nwr == 0) chk32($sformatf("v%0d_wb_wdata0", idx), bus_log[k].wdata, v.wr_data0);
                chk32($sformatf("v%0d_wb_addr%0d", idx, nwr), bus_log[k].addr, v.wr_base + 32'(4 * nwr));
                nwr++;
            end else begin
                chk32($sformatf("v%0d_rd_addr%0d", idx, nrd), bus_log[k].addr, v.rd_base + 32'(4 * nrd));
                nrd++;
            end
        end
        chk_int($sformatf("v%0d_bus_reads", idx), nrd, v.exp_rd);
        chk_int($sformatf("v%0d_bus_writes", idx), nwr, v.exp_wr);
        if (v.exp_wr > 0 && bus_log.size() > 0)
            chk_int($sformatf("v%0d_wb_before_fill", idx), int'(bus_log[0].wen), 1);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_int("reset_busreq_valid", int'(busreq_valid), 0);
        chk_int("reset_dreq_ready", int'(dreq_ready), 1);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic runFlush(input int exp_writes);
        int n;
        bus_log.delete();
        @(negedge clk);
        flush_valid = 1'b1;
        dreq_valid  = 1'b1;
        dreq_addr   = 32'h0;
        dreq_wen    = 1'b0;
        #1;
        chk_int("flush_wins_dreq_ready", int'(dreq_ready), 0);
        @(negedge clk);
        flush_valid = 1'b0;
        dreq_valid  = 1'b0;
        n = 0;
        while (!flush_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk_int("flush_done_seen", int'(flush_done), 1);
        @(negedge clk);
        chk_int("flush_done_one_cycle", int'(flush_done), 0);
        chk_int("flush_bus_writes", bus_log.size(), exp_writes);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] fl_addr[8];
        int          n;
        rst_n       = 1'b0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_wen    = 1'b0;
        dreq_wdata  = '0;
        dreq_wmask  = '0;
        flush_valid = 1'b0;

        vecs[0]  = '{32'h100, 1'b0, 32'h0,        4'h0, 32'h5A5A0100, 1'b0, 4, 0, 32'h100, 32'h0, 32'h0};
        vecs[1]  = '{32'h108, 1'b0, 32'h0,        4'h0, 32'h5A5A0108, 1'b1, 0, 0, 32'h0,   32'h0, 32'h0};
        vecs[2]  = '{32'h104, 1'b1, 32'hAABBCCDD, 4'h3, 32'h0,        1'b1, 0, 0, 32'h0,   32'h0, 32'h0};
        vecs[3]  = '{32'h104, 1'b0, 32'h0,        4'h0, 32'h5A5ACCDD, 1'b1, 0, 0, 32'h0,   32'h0, 32'h0};
        vecs[4]  = '{32'h000, 1'b1, 32'h11111111, 4'hF, 32'h0,        1'b0, 4, 0, 32'h000, 32'h0, 32'h0};
        vecs[5]  = '{32'h400, 1'b0, 32'h0,        4'h0, 32'h5A5A0400, 1'b0, 4, 0, 32'h400, 32'h0, 32'h0};
        vecs[6]  = '{32'h800, 1'b0, 32'h0,        4'h0, 32'h5A5A0800, 1'b0, 4, 4, 32'h800, 32'h0, 32'h11111111};
        vecs[7]  = '{32'h000, 1'b0, 32'h0,        4'h0, 32'h11111111, 1'b0, 4, 0, 32'h000, 32'h0, 32'h0};
        vecs[8]  = '{32'h80C, 1'b0, 32'h0,        4'h0, 32'h5A5A080C, 1'b1, 0, 0, 32'h0,   32'h0, 32'h0};
        vecs[9]  = '{32'h80C, 1'b1, 32'h12345678, 4'h8, 32'h0,        1'b1, 0, 0, 32'h0,   32'h0, 32'h0};
        vecs[10] = '{32'h80C, 1'b0, 32'h0,        4'h0, 32'h125A080C, 1'b1, 0, 0, 32'h0,   32'h0, 32'h0};

        repeat (2) @(negedge clk);
        chk_int("reset_dreq_ready", int'(dreq_ready), 1);
        chk_int("reset_busreq_valid", int'(busreq_valid), 0);
        chk_int("reset_dresp_valid", int'(dresp_valid), 0);
        chk_int("reset_flush_done", int'(flush_done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Fill with the bus stalling the first read for five cycles.
        stall_addrs.delete();
        stall_cycs.delete();
        stall_left = 5;
        v = '{32'h1F0, 1'b0, 32'h0, 4'h0, 32'h5A5A01F0, 1'b0, 4, 0, 32'h1F0, 32'h0, 32'h0};
        applyStimulus(v);
        checkOutput(v, 11);
        chk_int("stall_samples", stall_addrs.size(), 5);
        foreach (stall_addrs[k]) chk32($sformatf("stall_addr%0d", k), stall_addrs[k], 32'h1F0);
        if (stall_cycs.size() == 5) chk_int("stall_consecutive", stall_cycs[4] - stall_cycs[0], 4);

        // Two dirty lines, then flush; a second flush must be silent.
        applyReset();
        v = '{32'h000, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 4, 0, 32'h000, 32'h0, 32'h0};
        applyStimulus(v);
        checkOutput(v, 12);
        v = '{32'h210, 1'b1, 32'h0BADBEEF, 4'h1, 32'h0, 1'b0, 4, 0, 32'h210, 32'h0, 32'h0};
        applyStimulus(v);
        checkOutput(v, 13);
        fl_addr = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h210, 32'h214, 32'h218, 32'h21C};
        runFlush(8);
        if (bus_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk32($sformatf("flush_addr%0d", k), bus_log[k].addr, fl_addr[k]);
                chk_int($sformatf("flush_wen%0d", k), int'(bus_log[k].wen), 1);
            end
            chk32("flush_wdata_000", bus_log[0].wdata, 32'hCAFEF00D);
            chk32("flush_wdata_210", bus_log[4].wdata, 32'h5A5A02EF);
        end
        runFlush(0);
        v = '{32'h000, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 4, 0, 32'h000, 32'h0, 32'h0};
        applyStimulus(v);
        checkOutput(v, 14);

        // Reset while the second refill read is being requested.
        bus_log.delete();
        @(negedge clk);
        dreq_valid = 1'b1;
        dreq_addr  = 32'h300;
        dreq_wen   = 1'b0;
        @(negedge clk);
        dreq_valid = 1'b0;
        n = 0;
        while (!(busreq_valid && busreq_addr == 32'h304) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_int("second_fill_read_seen", int'(busreq_valid && busreq_addr == 32'h304), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_int("midfill_reset_busreq_valid", int'(busreq_valid), 0);
        chk_int("midfill_reset_dreq_ready", int'(dreq_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        v = '{32'h300, 1'b0, 32'h0, 4'h0, 32'h5A5A0300, 1'b0, 4, 0, 32'h300, 32'h0, 32'h0};
        applyStimulus(v);
        checkOutput(v, 15);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_dcache_assoc.md
Name: mem_dcache_assoc

Overview:
Parametrised set-associative, write-back, write-allocate data cache with multi-word lines and byte-masked writes. It sits between the memory stage and the shared word-wide memory bus, in the same position as the direct-mapped D-cache it supersedes. It adds associativity with round-robin replacement, line-granular fill and write-back, and an explicit flush operation.

Parameters:
INDEX_WIDTH, 6, log2 of the number of sets.
WAYS, 2, associativity; legal values are 1, 2 and 4.
LINE_WORDS, 4, 32-bit words per line; must be a power of two, at least 1. OW = log2(LINE_WORDS).

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
dreq_valid  in  1  CPU request valid.
dreq_ready  out  1  cache can accept a request.
dreq_addr  in  32  byte address; bits [1:0] are ignored.
dreq_wen  in  1  1 = write.
dreq_wdata  in  32  write data.
dreq_wmask  in  4  byte enables for writes.
dresp_valid  out  1  one-cycle response pulse, for reads and writes.
dresp_rdata  out  32  read data, valid while dresp_valid is high.
flush_valid  in  1  request write-back and invalidation of the whole cache.
flush_done  out  1  one-cycle pulse when the flush completes.
busreq_valid  out  1  bus request valid.
busreq_ready  in  1  bus accepts the request.
busreq_addr  out  32  word-aligned bus address.
busreq_wen  out  1  1 = bus write.
busreq_wdata  out  32  bus write data.
busresp_valid  in  1  bus read data valid.
busresp_rdata  in  32  bus read data.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset clears all valid and dirty bits, sets every replacement pointer to 0 and sets state to IDLE. dresp_valid, flush_done and busreq_valid are 0.
- Reset mid-operation abandons any bus transaction. The cycle after the reset edge shows busreq_valid=0 and dreq_ready=1.
- Address split: word = addr[2+OW-1:2]; index = next INDEX_WIDTH bits; tag = remaining upper bits.
- States: IDLE, WB, FILL, RESP, FLUSH.
- dreq_ready = (state==IDLE) && !flush_valid. When both flush_valid and dreq_valid are high in IDLE, flush wins.
- Hit (IDLE, accepted request, tag matches a valid way):
  - read: dresp_valid=1 next cycle with the word.
  - write: merge the bytes selected by wmask, set dirty, dresp_valid=1 next cycle (dresp_rdata don't-care).
  - No bus activity on a hit.
- Miss: latch the request and select a victim way.
  - Victim is the lowest-numbered invalid way; if none, the set's round-robin pointer, which then advances modulo WAYS.
  - If the victim is valid and dirty, go to WB; otherwise go to FILL.
- WB: LINE_WORDS bus writes, words 0..LINE_WORDS-1 in order, addr = {victim tag, index, word, 2'b00}. Each write completes on busreq_valid && busreq_ready. Then go to FILL.
- FILL: LINE_WORDS reads in word order.
  - Each read holds busreq_valid with a stable addr until ready, then drops valid and waits for busresp_valid.
  - Only one transaction is outstanding at a time.
  - After the last word, write the tag, set valid, clear dirty, then go to RESP.
- RESP: apply the latched write (merge, set dirty) or drive the latched read word. dresp_valid=1 for that cycle only, then IDLE.
- busreq address, wen and wdata are stable while busreq_valid=1 && busreq_ready=0.
- FLUSH:
  - Walks sets 0..2^INDEX_WIDTH-1; within each set, ways 0..WAYS-1.
  - Each dirty line is written back exactly as in WB.
  - Every line is invalidated and its dirty bit cleared.
  - Pointers are not changed.
  - flush_done pulses for one cycle on return to IDLE. A cache with no dirty lines completes with no bus traffic.
- busresp_valid outside FILL-wait is ignored.

Test Plan:
Config INDEX_WIDTH=6, WAYS=2, LINE_WORDS=4, so the set stride is 0x400. Memory model: mem[a]=a^0x5A5A0000.
1. Cold read 0x100 -> bus reads at 0x100, 0x104, 0x108, 0x10C, no bus writes, dresp_rdata=0x5A5A0100. Then read 0x108 -> dresp_valid the cycle after acceptance, rdata 0x5A5A0108, zero bus requests.
2. After case 1, write 0x104 wdata=0xAABBCCDD wmask=4'b0011 -> hit, no bus traffic. Read 0x104 -> 0x5A5ACCDD.
3. Write 0x000 wdata=0x11111111 mask=1111, then read 0x400, then read 0x800 -> the third access evicts way0:
   - 4 bus writes at 0x000..0x00C, with the first wdata 0x11111111;
   - then 4 reads at 0x800..0x80C; dresp_rdata=0x5A5A0800.
4. Hold busreq_ready=0 for 5 cycles during a fill -> busreq_valid=1 and busreq_addr unchanged for all 5 cycles, exactly one transaction per word.
5. Dirty lines at 0x000 and 0x210, then flush_valid=1 -> exactly 8 bus writes (0x000..0x00C, then 0x210..0x21C), then flush_done for one cycle. A following read of 0x000 misses and refetches.
6. Assert rst_n=0 during the second fill read, then release -> next cycle busreq_valid=0, dreq_ready=1. A read of the same address misses with 4 bus reads.
